// File: rtl/phy_rx_unstriper.sv
// phy_rx_unstriper: receive-side two-lane byte unstriper.
// Each lane feeds a small deskew FIFO. Byte pairs are popped together and
// reassembled into 32-bit words (lane0 = upper byte of each half-word).
// Optional feature macro: PHY_RX_ERR_CNT_EN adds a saturating err_count output.
module phy_rx_unstriper #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic        active,
    input  logic [7:0]  data_in_0,
    input  logic [7:0]  data_in_1,
    input  logic        valid_in_0,
    input  logic        valid_in_1,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        half_pending,
    output logic        skew_err
`ifdef PHY_RX_ERR_CNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HALF  = 1'b1
    } state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    // Per-lane FIFO storage and bookkeeping
    logic [7:0]       r_mem [2][DEPTH];
    logic [PTR_W-1:0] r_wr  [2];
    logic [PTR_W-1:0] r_rd  [2];
    logic [PTR_W:0]   r_cnt [2];

    logic [7:0]  w_din   [2];
    logic [7:0]  w_dout  [2];
    logic [1:0]  w_push;
    logic [1:0]  w_full;
    logic [1:0]  w_nempty;
    logic        w_pop;
    logic        w_ovf;
    logic        w_flush;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_hi;
    logic [31:0] r_data;
    logic        r_valid;
    logic        r_half;
    logic        r_skew;

    assign w_din[0]  = data_in_0;
    assign w_din[1]  = data_in_1;
    assign w_dout[0] = r_mem[0][r_rd[0]];
    assign w_dout[1] = r_mem[1][r_rd[1]];

    assign w_push    = {active & valid_in_1, active & valid_in_0};
    assign w_full    = {(r_cnt[1] == FULL_CNT), (r_cnt[0] == FULL_CNT)};
    assign w_nempty  = {(r_cnt[1] != '0), (r_cnt[0] != '0)};

    // A pair pops only when both lanes hold a byte; lanes never pop alone.
    assign w_pop     = active & (&w_nempty);
    // Writing a full FIFO that is not draining this cycle means skew exceeded the budget.
    assign w_ovf     = (|(w_push & w_full)) & ~w_pop;
    assign w_flush   = ~active | w_ovf;

    // Lane FIFOs: push/pop pointers and occupancy, flushed on inactive link or overflow
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            for (int l = 0; l < 2; l++) begin
                r_wr[l]  <= '0;
                r_rd[l]  <= '0;
                r_cnt[l] <= '0;
                for (int d = 0; d < DEPTH; d++) begin
                    r_mem[l][d] <= 8'h00;
                end
            end
        end else if (w_flush) begin
            for (int l = 0; l < 2; l++) begin
                r_wr[l]  <= '0;
                r_rd[l]  <= '0;
                r_cnt[l] <= '0;
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (w_push[l]) begin
                    r_mem[l][r_wr[l]] <= w_din[l];
                    r_wr[l]           <= r_wr[l] + 1'b1;
                end
                if (w_pop) begin
                    r_rd[l] <= r_rd[l] + 1'b1;
                end
                case ({w_push[l], w_pop})
                    2'b10:   r_cnt[l] <= r_cnt[l] + 1'b1;
                    2'b01:   r_cnt[l] <= r_cnt[l] - 1'b1;
                    default: r_cnt[l] <= r_cnt[l];
                endcase
            end
        end
    end

    // Assembler state register
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Assembler next state: each pair pop toggles between upper and lower half-word
    always_comb begin
        w_state_nxt = r_state;
        if (w_flush) begin
            w_state_nxt = S_EMPTY;
        end else if (w_pop) begin
            case (r_state)
                S_EMPTY: w_state_nxt = S_HALF;
                S_HALF:  w_state_nxt = S_EMPTY;
                default: w_state_nxt = S_EMPTY;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Word assembly and registered outputs; data_out holds between words
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            r_hi    <= 16'h0000;
            r_data  <= 32'h0000_0000;
            r_valid <= 1'b0;
            r_half  <= 1'b0;
            r_skew  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_skew  <= w_ovf;
            r_half  <= (w_state_nxt == S_HALF);
            if (w_pop && (r_state == S_EMPTY)) begin
                r_hi <= {w_dout[0], w_dout[1]};
            end
            if (w_pop && (r_state == S_HALF)) begin
                r_data  <= {r_hi, w_dout[0], w_dout[1]};
                r_valid <= 1'b1;
            end
        end
    end

    assign data_out     = r_data;
    assign valid_out    = r_valid;
    assign half_pending = r_half;
    assign skew_err     = r_skew;

`ifdef PHY_RX_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    // Saturating count of overflow events; only reset clears it
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            r_err_cnt <= 8'h00;
        end else if (w_ovf && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'h01;
        end else begin
            r_err_cnt <= r_err_cnt;
        end
    end

    assign err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_phy_rx_unstriper.sv
// Scoreboard bench for phy_rx_unstriper: directed lane stimulus pushes expected
// words into a queue; a negedge monitor pops and compares on every valid_out.
module tb_phy_rx_unstriper;

    logic        clk_4f = 1'b0;
    logic        reset;
    logic        active;
    logic [7:0]  data_in_0;
    logic [7:0]  data_in_1;
    logic        valid_in_0;
    logic        valid_in_1;
    logic [31:0] data_out;
    logic        valid_out;
    logic        half_pending;
    logic        skew_err;
`ifdef PHY_RX_ERR_CNT_EN
    logic [7:0]  err_count;
`endif

    phy_rx_unstriper #(.DEPTH(4), .PTR_W(2)) dut (
        .clk_4f       (clk_4f),
        .reset        (reset),
        .active       (active),
        .data_in_0    (data_in_0),
        .data_in_1    (data_in_1),
        .valid_in_0   (valid_in_0),
        .valid_in_1   (valid_in_1),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .half_pending (half_pending),
        .skew_err     (skew_err)
`ifdef PHY_RX_ERR_CNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    always #5 clk_4f = ~clk_4f;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_skew   = 0;
    int          e_cyc;
    int          exp_skew;
    logic        prev_valid = 1'b0;
    logic [31:0] exp_q [$];
    int          vcyc  [$];

    always @(posedge clk_4f) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented word against the scoreboard head
    always @(negedge clk_4f) begin
        if (reset === 1'b1) begin
            if (valid_out) begin
                vcyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h expected none", data_out);
                end else begin
                    check("data_out", data_out, exp_q.pop_front());
                end
                check("valid_single_pulse", {31'd0, prev_valid}, 32'd0);
            end
            if (skew_err) n_skew++;
            prev_valid = valid_out;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic beat(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
        valid_in_0 = v0;
        data_in_0  = d0;
        valid_in_1 = v1;
        data_in_1  = d1;
        @(posedge clk_4f);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        active     = 1'b0;
        data_in_0  = 8'h00;
        data_in_1  = 8'h00;
        valid_in_0 = 1'b0;
        valid_in_1 = 1'b0;
        repeat (2) @(posedge clk_4f);
        #1;
        check("rst_data_out", data_out, 32'h0);
        check("rst_valid_out", {31'd0, valid_out}, 32'd0);
        check("rst_half_pending", {31'd0, half_pending}, 32'd0);
        check("rst_skew_err", {31'd0, skew_err}, 32'd0);
`ifdef PHY_RX_ERR_CNT_EN
        check("rst_err_count", {24'd0, err_count}, 32'd0);
`endif
        reset  = 1'b1;
        active = 1'b1;
        idle(2);

        // Aligned stream, latency and spacing
        vcyc.delete();
        exp_q.push_back(32'hFFFF_EEEE);
        exp_q.push_back(32'hAAAA_1234);
        beat(1'b1, 8'hFF, 1'b1, 8'hFF);
        check("aligned_half_before", {31'd0, half_pending}, 32'd0);
        beat(1'b1, 8'hEE, 1'b1, 8'hEE);
        e_cyc = cyc;
        check("aligned_half_after_pop", {31'd0, half_pending}, 32'd1);
        beat(1'b1, 8'hAA, 1'b1, 8'hAA);
        beat(1'b1, 8'h12, 1'b1, 8'h34);
        idle(4);
        check("aligned_word_count", vcyc.size(), 32'd2);
        if (vcyc.size() >= 2) begin
            check("aligned_latency", vcyc[0], e_cyc + 1);
            check("aligned_spacing", vcyc[1] - vcyc[0], 32'd2);
        end
        check("aligned_queue_empty", exp_q.size(), 32'd0);
        check("aligned_no_skew", n_skew, 32'd0);

        // Lane 1 lags lane 0 by two beats
        exp_q.push_back(32'h1234_5678);
        exp_q.push_back(32'hBBBB_AAAA);
        beat(1'b1, 8'h12, 1'b0, 8'h00);
        beat(1'b1, 8'h56, 1'b0, 8'h00);
        beat(1'b1, 8'hBB, 1'b1, 8'h34);
        beat(1'b1, 8'hAA, 1'b1, 8'h78);
        check("skew_half_between", {31'd0, half_pending}, 32'd1);
        beat(1'b0, 8'h00, 1'b1, 8'hBB);
        beat(1'b0, 8'h00, 1'b1, 8'hAA);
        idle(4);
        check("skew_queue_empty", exp_q.size(), 32'd0);
        check("skew_no_err", n_skew, 32'd0);

        // Lane 0 overruns its FIFO while lane 1 is idle
        vcyc.delete();
        for (int i = 0; i < 4; i++) beat(1'b1, 8'h11, 1'b0, 8'h00);
        check("ovf_no_err_at_full", {31'd0, skew_err}, 32'd0);
        beat(1'b1, 8'h11, 1'b0, 8'h00);
        check("ovf_skew_err_pulse", {31'd0, skew_err}, 32'd1);
        idle(1);
        check("ovf_skew_err_clear", {31'd0, skew_err}, 32'd0);
        check("ovf_skew_count", n_skew, 32'd1);
        check("ovf_no_word", vcyc.size(), 32'd0);
`ifdef PHY_RX_ERR_CNT_EN
        check("ovf_err_count", {24'd0, err_count}, 32'd1);
`endif
        exp_q.push_back(32'h0102_0304);
        beat(1'b1, 8'h01, 1'b1, 8'h02);
        beat(1'b1, 8'h03, 1'b1, 8'h04);
        idle(3);
        check("ovf_flushed_queue_empty", exp_q.size(), 32'd0);

        // Link drop discards a held half-word
        beat(1'b1, 8'hCC, 1'b1, 8'hEE);
        idle(1);
        check("drop_half_held", {31'd0, half_pending}, 32'd1);
        active = 1'b0;
        idle(1);
        check("drop_half_cleared", {31'd0, half_pending}, 32'd0);
        active = 1'b1;
        exp_q.push_back(32'hFFEE_EEEE);
        beat(1'b1, 8'hFF, 1'b1, 8'hEE);
        beat(1'b1, 8'hEE, 1'b1, 8'hEE);
        idle(3);
        check("drop_queue_empty", exp_q.size(), 32'd0);
        check("drop_data_hold", data_out, 32'hFFEE_EEEE);

        // Asynchronous reset while a half-word is held
        beat(1'b1, 8'hFF, 1'b1, 8'hFF);
        idle(1);
        check("rst_mid_half_before", {31'd0, half_pending}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_data_out", data_out, 32'h0);
        check("rst_mid_valid_out", {31'd0, valid_out}, 32'd0);
        check("rst_mid_half_pending", {31'd0, half_pending}, 32'd0);
        check("rst_mid_skew_err", {31'd0, skew_err}, 32'd0);
        @(posedge clk_4f);
        #1;
        reset = 1'b1;
        exp_q.push_back(32'hFFFF_EEEE);
        beat(1'b1, 8'hFF, 1'b1, 8'hFF);
        beat(1'b1, 8'hEE, 1'b1, 8'hEE);
        idle(3);
        check("rst_mid_queue_empty", exp_q.size(), 32'd0);
        exp_skew = 1;

`ifdef PHY_RX_ERR_CNT_EN
        // Counter cleared by the mid-test reset; drive 300 more overflows
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 5; i++) beat(1'b1, 8'h55, 1'b0, 8'h00);
        end
        idle(1);
        check("err_count_saturate", {24'd0, err_count}, 32'h0000_00FF);
        exp_skew = 301;
`endif
        check("total_skew_pulses", n_skew, exp_skew);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
